stats_poller: RTL and testbench

STATS_POLLER -- requirements
Module: stats_poller

---
 rtl/stats_poller.sv | 175 +++++++++++++++++
 tb/tb_stats_poller.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stats_poller.sv
// Periodic APB statistics poller: sweeps every slave, streams each word out,
// and optionally zeroes the counter words of a slave once its record is sent.
module stats_poller #(
    parameter int NumSlaves = 4,
    parameter int NumWords  = 4,
    parameter int TmrBits   = 24,
    localparam int IdW = (NumSlaves > 1) ? $clog2(NumSlaves) : 1,
    localparam int WW  = (NumWords > 1) ? $clog2(NumWords) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [TmrBits-1:0]      interval,
    input  logic                    clear_on_read,
    output logic [4:0]              m_paddr,
    output logic [NumSlaves-1:0]    m_psel,
    output logic                    m_penable,
    output logic                    m_pwrite,
    output logic [31:0]             m_pwdata,
    input  logic [NumSlaves-1:0]    m_pready,
    input  logic [32*NumSlaves-1:0] m_prdata,
    output logic                    dout_valid,
    output logic [31:0]             dout_data,
    output logic [IdW-1:0]          dout_id,
    output logic                    dout_eof,
    input  logic                    dout_ready,
    output logic                    busy,
    output logic                    overrun
);

    // state     | meaning
    // IDLE      | waiting for timer expiry
    // RD_SETUP  | APB read setup phase, slave s word w
    // RD_ACCESS | APB read access phase, wait for pready
    // OUT       | present captured word on result stream
    // WR_SETUP  | APB write-zero setup phase (clear_on_read)
    // WR_ACCESS | APB write-zero access phase, wait for pready
    typedef enum logic [2:0] {
        IDLE, RD_SETUP, RD_ACCESS, OUT, WR_SETUP, WR_ACCESS
    } state_t;

    state_t             state_q, state_d;
    logic [IdW-1:0]     s_q, s_d;
    logic [WW-1:0]      w_q, w_d;
    logic [31:0]        data_q, data_d;
    logic               cor_q, cor_d;
    logic [TmrBits-1:0] tmr_q;
    logic               tmr_load_q;
    logic               overrun_q;

    logic               expire;
    logic               sel_ready;
    logic [31:0]        rd_word;
    logic               last_w, last_s, adv;
    logic               setup, access;

    // The timer is reloaded on the first edge after reset so interval is
    // never taken from a value sampled while the block was held in reset.
    assign expire = !tmr_load_q && enable && (tmr_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q      <= '0;
            tmr_load_q <= 1'b1;
            overrun_q  <= 1'b0;
        end else begin
            if (tmr_load_q || expire) begin
                tmr_q      <= interval;
                tmr_load_q <= 1'b0;
            end else if (enable) begin
                tmr_q <= tmr_q - TmrBits'(1);
            end
            if (expire && state_q != IDLE)
                overrun_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            w_q     <= '0;
            data_q  <= '0;
            cor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            w_q     <= w_d;
            data_q  <= data_d;
            cor_q   <= cor_d;
        end
    end

    assign sel_ready = m_pready[s_q];
    assign rd_word   = m_prdata[int'(s_q)*32 +: 32];
    assign last_w    = (w_q == WW'(NumWords - 1));
    assign last_s    = (s_q == IdW'(NumSlaves - 1));

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        w_d     = w_q;
        data_d  = data_q;
        cor_d   = cor_q;
        adv     = 1'b0;
        case (state_q)
            IDLE: begin
                if (expire) begin
                    state_d = RD_SETUP;
                    s_d     = '0;
                    w_d     = '0;
                    cor_d   = clear_on_read;
                end
            end
            RD_SETUP: state_d = RD_ACCESS;
            RD_ACCESS: begin
                if (sel_ready) begin
                    data_d  = rd_word;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (dout_ready) begin
                    if (!last_w) begin
                        w_d     = w_q + WW'(1);
                        state_d = RD_SETUP;
                    end else if (cor_q && (NumWords > 1)) begin
                        w_d     = WW'(1);
                        state_d = WR_SETUP;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            WR_SETUP: state_d = WR_ACCESS;
            WR_ACCESS: begin
                if (sel_ready) begin
                    if (!last_w) begin
                        w_d     = w_q + WW'(1);
                        state_d = WR_SETUP;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (adv) begin
            w_d = '0;
            if (!last_s) begin
                s_d     = s_q + IdW'(1);
                state_d = RD_SETUP;
            end else begin
                s_d     = '0;
                state_d = IDLE;
            end
        end
    end

    assign setup  = (state_q == RD_SETUP) || (state_q == WR_SETUP);
    assign access = (state_q == RD_ACCESS) || (state_q == WR_ACCESS);

    assign m_psel     = (setup || access) ? (NumSlaves'(1) << s_q) : '0;
    assign m_penable  = access;
    assign m_pwrite   = (state_q == WR_SETUP) || (state_q == WR_ACCESS);
    assign m_paddr    = (setup || access) ? 5'({w_q, 2'b00}) : 5'd0;
    assign m_pwdata   = 32'd0;
    assign dout_valid = (state_q == OUT);
    assign dout_data  = data_q;
    assign dout_id    = s_q;
    assign dout_eof   = (state_q == OUT) && last_w;
    assign busy       = (state_q != IDLE);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_stats_poller.sv
// Directed bench for stats_poller: two zero-wait slaves returning 0x100*s+w,
// with programmable slave and result-stream stalls.
module tb_stats_poller;

    localparam int NS = 2;
    localparam int NW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        clear_on_read = 1'b0;
    logic [23:0] interval = 24'd10;
    logic [4:0]  m_paddr;
    logic [1:0]  m_psel;
    logic        m_penable, m_pwrite;
    logic [31:0] m_pwdata;
    logic [1:0]  m_pready;
    logic [63:0] m_prdata;
    logic        dout_valid;
    logic [31:0] dout_data;
    logic [0:0]  dout_id;
    logic        dout_eof, dout_ready, busy, overrun;

    stats_poller #(.NumSlaves(NS), .NumWords(NW), .TmrBits(24)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .interval(interval),
        .clear_on_read(clear_on_read), .m_paddr(m_paddr), .m_psel(m_psel),
        .m_penable(m_penable), .m_pwrite(m_pwrite), .m_pwdata(m_pwdata),
        .m_pready(m_pready), .m_prdata(m_prdata), .dout_valid(dout_valid),
        .dout_data(dout_data), .dout_id(dout_id), .dout_eof(dout_eof),
        .dout_ready(dout_ready), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // slave model
    always_comb m_prdata = {32'h100 + 32'(m_paddr >> 2), 32'(m_paddr >> 2)};

    logic       st_en = 1'b0;
    int         st_slave = 0;
    logic [4:0] st_addr = 5'd0;
    int         st_len = 0;
    int         acc_cnt = 0;
    logic       tgt_acc;

    always_comb tgt_acc = st_en && m_psel[st_slave] && m_penable && !m_pwrite && (m_paddr == st_addr);
    always_comb begin
        m_pready = '1;
        if (tgt_acc && acc_cnt < st_len) m_pready[st_slave] = 1'b0;
    end
    always @(posedge clk) begin
        if (!st_en) acc_cnt <= 0;
        else if (tgt_acc) acc_cnt <= acc_cnt + 1;
    end

    // result-stream backpressure model
    logic rs_en = 1'b0;
    int   rs_beat = 0;
    int   rs_len = 0;
    int   out_cnt = 0;
    int   acc_beats = 0;

    always_comb dout_ready = !(rs_en && acc_beats == rs_beat && out_cnt < rs_len);
    always @(posedge clk) begin
        if (!rs_en) begin
            out_cnt   <= 0;
            acc_beats <= 0;
        end else begin
            if (dout_valid && acc_beats == rs_beat) out_cnt <= out_cnt + 1;
            if (dout_valid && dout_ready) acc_beats <= acc_beats + 1;
        end
    end

    // monitor
    logic [31:0] beat_data[$];
    int          beat_id[$];
    logic        beat_eof[$];
    int          wr_addr[$], wr_sel[$], wr_nb[$];
    int          nbeat, busy_cyc, sweeps, s1_acc, prot_err, hold_err, stall_cyc;
    logic        busy_prev, prev_stall, pi, pe;
    logic [31:0] pd;

    task automatic clear_log();
        beat_data.delete(); beat_id.delete(); beat_eof.delete();
        wr_addr.delete(); wr_sel.delete(); wr_nb.delete();
        nbeat = 0; busy_cyc = 0; sweeps = 0; s1_acc = 0;
        prot_err = 0; hold_err = 0; stall_cyc = 0;
        busy_prev = 1'b0; prev_stall = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cyc++;
            if (busy && !busy_prev) sweeps++;
            busy_prev = busy;
            if (dout_valid && dout_ready) begin
                beat_data.push_back(dout_data);
                beat_id.push_back(int'(dout_id));
                beat_eof.push_back(dout_eof);
                nbeat++;
            end
            if (m_psel == 2'b10 && m_penable && !m_pwrite) s1_acc++;
            if (m_penable && m_pwrite && (m_psel & m_pready) != 2'b00) begin
                wr_addr.push_back(int'(m_paddr));
                wr_sel.push_back(int'(m_psel));
                wr_nb.push_back(nbeat);
            end
            if (!$onehot0(m_psel)) prot_err++;
            if (m_penable && m_psel == 2'b00) prot_err++;
            if (dout_valid && m_psel != 2'b00) prot_err++;
            if (m_pwdata != 32'd0) prot_err++;
            if (prev_stall && (!dout_valid || dout_data != pd || dout_id != pi || dout_eof != pe))
                hold_err++;
            if (dout_valid && !dout_ready) stall_cyc++;
            prev_stall = dout_valid && !dout_ready;
            pd = dout_data; pi = dout_id[0]; pe = dout_eof;
        end else begin
            busy_prev  = 1'b0;
            prev_stall = 1'b0;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        clear_log();
    endtask

    // release reset with enable high and measure edges until busy appears
    task automatic start_sweep(input string tag);
        int lat;
        @(posedge clk);
        #1 rst_n = 1'b1;
        enable = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!busy && lat < 200);
        chk({tag, "_start_lat"}, lat, 12);
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic check_sweep(input string tag);
        chk({tag, "_nbeat"}, nbeat, 8);
        for (int i = 0; i < 8 && i < nbeat; i++) begin
            chk($sformatf("%s_id%0d", tag, i), beat_id[i], i / 4);
            chk($sformatf("%s_data%0d", tag, i), beat_data[i], 32'h100 * (i / 4) + i % 4);
            chk($sformatf("%s_eof%0d", tag, i), beat_eof[i], (i % 4) == 3);
        end
        chk({tag, "_prot"}, prot_err, 0);
    endtask

    initial begin
        int n;
        logic found;
        clear_log();

        // reset state
        @(negedge clk);
        chk("rst_psel", m_psel, 0);
        chk("rst_penable", m_penable, 0);
        chk("rst_pwrite", m_pwrite, 0);
        chk("rst_paddr", m_paddr, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);

        // basic sweep; enable dropped mid-sweep lets it finish
        do_reset();
        start_sweep("t1");
        enable = 1'b0;
        wait_idle("t1", 200);
        check_sweep("t1");
        chk("t1_busy_cyc", busy_cyc, 24);
        repeat (20) @(negedge clk);
        chk("t1_sweeps", sweeps, 1);
        chk("t1_overrun", overrun, 0);

        // slave 1 word 2 stalled 5 cycles
        do_reset();
        st_en = 1'b1; st_slave = 1; st_addr = 5'd8; st_len = 5;
        start_sweep("t2");
        enable = 1'b0;
        wait_idle("t2", 200);
        check_sweep("t2");
        chk("t2_busy_cyc", busy_cyc, 29);
        chk("t2_s1_acc", s1_acc, 9);
        st_en = 1'b0;

        // result stream stalled 7 cycles on beat 3
        do_reset();
        rs_en = 1'b1; rs_beat = 2; rs_len = 7;
        start_sweep("t3");
        enable = 1'b0;
        wait_idle("t3", 200);
        check_sweep("t3");
        chk("t3_busy_cyc", busy_cyc, 31);
        chk("t3_stall_cyc", stall_cyc, 7);
        chk("t3_hold", hold_err, 0);
        rs_en = 1'b0;

        // clear on read
        do_reset();
        clear_on_read = 1'b1;
        start_sweep("t4");
        enable = 1'b0;
        clear_on_read = 1'b0;
        wait_idle("t4", 200);
        check_sweep("t4");
        chk("t4_busy_cyc", busy_cyc, 36);
        chk("t4_nwr", wr_addr.size(), 6);
        for (int i = 0; i < 6 && i < wr_addr.size(); i++) begin
            chk($sformatf("t4_wr_addr%0d", i), wr_addr[i], 4 * (i % 3 + 1));
            chk($sformatf("t4_wr_sel%0d", i), wr_sel[i], (i < 3) ? 1 : 2);
            chk($sformatf("t4_wr_nb%0d", i), wr_nb[i], (i < 3) ? 4 : 8);
        end

        // overrun: interval 3, slave 0 word 0 stalled 20 cycles
        do_reset();
        interval = 24'd3;
        st_en = 1'b1; st_slave = 0; st_addr = 5'd0; st_len = 20;
        @(posedge clk);
        #1 rst_n = 1'b1;
        enable = 1'b1;
        n = 0;
        while (!busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_start", busy, 1'b1);
        wait_idle("t5", 200);
        chk("t5_overrun", overrun, 1'b1);
        chk("t5_sweeps", sweeps, 1);
        chk("t5_nbeat", nbeat, 8);
        chk("t5_busy_cyc", busy_cyc, 44);
        st_en = 1'b0;
        enable = 1'b0;
        repeat (60) @(negedge clk);
        chk("t5_overrun_sticky", overrun, 1'b1);
        interval = 24'd10;

        // reset during slave 1 read access
        do_reset();
        start_sweep("t6");
        found = 1'b0;
        n = 0;
        while (!found && n < 200) begin
            @(negedge clk);
            n++;
            found = (m_psel == 2'b10) && m_penable && !m_pwrite;
        end
        chk("t6_found_access", found, 1'b1);
        chk("t6_ovr_pre", overrun, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_psel", m_psel, 0);
        chk("t6_penable", m_penable, 0);
        chk("t6_paddr", m_paddr, 0);
        chk("t6_valid", dout_valid, 0);
        chk("t6_data", dout_data, 0);
        chk("t6_busy", busy, 0);
        chk("t6_overrun", overrun, 0);
        clear_log();
        start_sweep("t6r");
        n = 0;
        while (nbeat < 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t6r_nbeat", nbeat >= 1, 1'b1);
        if (nbeat >= 1) begin
            chk("t6r_id0", beat_id[0], 0);
            chk("t6r_data0", beat_data[0], 0);
        end
        enable = 1'b0;
        wait_idle("t6r", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
